// File: rtl/ysyx_24100012_pkg.sv
// Shared IFU definitions: fetch FSM state encoding, the canonical NOP and reset PC.
package ysyx_24100012_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } ifu_state_e;

  localparam logic [31:0] IFU_NOP         = 32'h00000013;
  localparam logic [31:0] IFU_ORIGIN_ADDR = 32'h80000000;

endpackage

// File: rtl/ysyx_24100012_Reg.sv
// Generic write-enabled register with asynchronous active-low reset to RESET_VAL.
module ysyx_24100012_Reg #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     dout <= RESET_VAL;
    else if (wen) dout <= din;
  end

endmodule

// File: rtl/ysyx_24100012_ifu_req.sv
// Instruction fetch requester: issues one memory request per PC, holds the word until consumed.
// Optional perf counters with YSYX_24100012_IFU_PERF_EN.  States: IDLE|post-reset  REQ|request  WAIT|response  HOLD|offer inst
module ysyx_24100012_ifu_req
  import ysyx_24100012_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] ORIGIN_ADDR = ADDR_WIDTH'(IFU_ORIGIN_ADDR)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,
  input  logic                  mem_rsp_err,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic [ADDR_WIDTH-1:0] inst_pc_next,
  output logic                  inst_err,
`ifdef YSYX_24100012_IFU_PERF_EN
  output logic [31:0]           perf_fetch_cnt,
  output logic [31:0]           perf_stall_cnt,
`endif
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc
);

  ifu_state_e            state_q, state_d;
  logic                  mem_req_valid_q, mem_req_valid_d;
  logic                  inst_valid_q, inst_valid_d;
  logic [DATA_WIDTH-1:0] inst_q, inst_d;
  logic                  inst_err_q, inst_err_d;
  logic [ADDR_WIDTH-1:0] pc, pc_d;
  logic                  accept;

  assign accept = inst_valid_q && inst_ready;
  // Redirect targets are forced word-aligned.
  assign pc_d   = redirect_valid ? (redirect_pc & ~ADDR_WIDTH'(3)) : pc + ADDR_WIDTH'(4);

  ysyx_24100012_Reg #(
    .WIDTH    (ADDR_WIDTH),
    .RESET_VAL(ORIGIN_ADDR)
  ) u_pc (
    .clk (clk),
    .rst (rst),
    .wen (accept),
    .din (pc_d),
    .dout(pc)
  );

  always_comb begin
    state_d    = state_q;
    inst_d     = inst_q;
    inst_err_d = inst_err_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ:  if (mem_req_ready) state_d = WAIT;
      WAIT: if (mem_rsp_valid) begin
        state_d    = HOLD;
        inst_d     = mem_rsp_data;
        inst_err_d = mem_rsp_err;
      end
      HOLD: if (inst_ready) state_d = REQ;
      default: state_d = IDLE;
    endcase
    mem_req_valid_d = (state_d == REQ);
    inst_valid_d    = (state_d == HOLD);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      mem_req_valid_q <= 1'b0;
      inst_valid_q    <= 1'b0;
      inst_q          <= '0;
      inst_err_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      mem_req_valid_q <= mem_req_valid_d;
      inst_valid_q    <= inst_valid_d;
      inst_q          <= inst_d;
      inst_err_q      <= inst_err_d;
    end
  end

  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_addr  = pc;
  assign inst_valid    = inst_valid_q;
  assign inst          = inst_q;
  assign inst_err      = inst_err_q;
  assign inst_pc       = pc;
  assign inst_pc_next  = pc + ADDR_WIDTH'(4);

`ifdef YSYX_24100012_IFU_PERF_EN
  logic [31:0] perf_fetch_cnt_q, perf_fetch_cnt_d;
  logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;
  logic        stall;

  assign stall = ((state_q == REQ) && !mem_req_ready) || ((state_q == WAIT) && !mem_rsp_valid);

  always_comb begin
    perf_fetch_cnt_d = perf_fetch_cnt_q + (accept ? 32'd1 : 32'd0);
    perf_stall_cnt_d = perf_stall_cnt_q + (stall ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch_cnt_q <= '0;
      perf_stall_cnt_q <= '0;
    end else begin
      perf_fetch_cnt_q <= perf_fetch_cnt_d;
      perf_stall_cnt_q <= perf_stall_cnt_d;
    end
  end

  assign perf_fetch_cnt = perf_fetch_cnt_q;
  assign perf_stall_cnt = perf_stall_cnt_q;
`endif

endmodule

// File: tb/tb_ysyx_24100012_ifu_req.sv
// Randomized bench for the IFU requester against a transaction-level PC/counter model.
module tb_ysyx_24100012_ifu_req;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid, mem_rsp_err;
  logic [31:0] mem_rsp_data;
  logic        inst_valid, inst_ready, inst_err;
  logic [31:0] inst, inst_pc, inst_pc_next;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef YSYX_24100012_IFU_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

  ysyx_24100012_ifu_req dut (
    .clk           (clk),
    .rst           (rst),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .mem_rsp_err   (mem_rsp_err),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_pc_next  (inst_pc_next),
    .inst_err      (inst_err),
`ifdef YSYX_24100012_IFU_PERF_EN
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_stall_cnt(perf_stall_cnt),
`endif
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] exp_pc;
  int          exp_fetch;
  int          exp_stall;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state();
    check("rst_req_valid", 64'(mem_req_valid), 64'd0);
    check("rst_inst_valid", 64'(inst_valid), 64'd0);
    check("rst_inst", 64'(inst), 64'd0);
    check("rst_inst_err", 64'(inst_err), 64'd0);
    check("rst_pc", 64'(mem_req_addr), 64'h80000000);
  endtask

  task automatic check_perf();
`ifdef YSYX_24100012_IFU_PERF_EN
    check("perf_fetch", 64'(perf_fetch_cnt), 64'(exp_fetch));
    check("perf_stall", 64'(perf_stall_cnt), 64'(exp_stall));
`endif
  endtask

  // Entered in a REQ cycle; leaves in the REQ cycle of the following fetch.
  task automatic fetch(input int sreq, input int swait, input int shold,
                       input logic [31:0] data, input logic err,
                       input logic redir, input logic [31:0] rpc);
    logic [31:0] this_pc, this_next;
    this_pc   = exp_pc;
    this_next = exp_pc + 32'd4;
    check("req_valid", 64'(mem_req_valid), 64'd1);
    check("req_addr", 64'(mem_req_addr), 64'(this_pc));
    check("inst_valid_req", 64'(inst_valid), 64'd0);
    for (int i = 0; i < sreq; i++) begin
      mem_req_ready  = 1'b0;
      mem_rsp_valid  = 1'($urandom_range(0, 1));
      mem_rsp_data   = $urandom;
      inst_ready     = 1'($urandom_range(0, 1));
      redirect_valid = 1'($urandom_range(0, 1));
      redirect_pc    = $urandom;
      step();
      check("req_stall_valid", 64'(mem_req_valid), 64'd1);
      check("req_stall_addr", 64'(mem_req_addr), 64'(this_pc));
      check("req_stall_inst_valid", 64'(inst_valid), 64'd0);
    end
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    check("wait_req_valid", 64'(mem_req_valid), 64'd0);
    check("wait_inst_valid", 64'(inst_valid), 64'd0);
    for (int i = 0; i < swait; i++) begin
      mem_rsp_data   = $urandom;
      inst_ready     = 1'($urandom_range(0, 1));
      redirect_valid = 1'($urandom_range(0, 1));
      step();
      check("wait_stall_req_valid", 64'(mem_req_valid), 64'd0);
      check("wait_stall_inst_valid", 64'(inst_valid), 64'd0);
    end
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = data;
    mem_rsp_err   = err;
    step();
    for (int i = 0; i <= shold; i++) begin
      check("hold_inst_valid", 64'(inst_valid), 64'd1);
      check("hold_inst", 64'(inst), 64'(data));
      check("hold_inst_err", 64'(inst_err), 64'(err));
      check("hold_inst_pc", 64'(inst_pc), 64'(this_pc));
      check("hold_inst_pc_next", 64'(inst_pc_next), 64'(this_next));
      check("hold_req_valid", 64'(mem_req_valid), 64'd0);
      if (i < shold) begin
        inst_ready     = 1'b0;
        mem_rsp_valid  = 1'($urandom_range(0, 1));
        mem_rsp_data   = ~data;
        mem_rsp_err    = ~err;
        mem_req_ready  = 1'($urandom_range(0, 1));
        redirect_valid = 1'($urandom_range(0, 1));
        redirect_pc    = $urandom;
        step();
      end
    end
    inst_ready     = 1'b1;
    redirect_valid = redir;
    redirect_pc    = rpc;
    mem_rsp_valid  = 1'b0;
    mem_req_ready  = 1'b0;
    step();
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    exp_pc    = redir ? {rpc[31:2], 2'b00} : this_next;
    exp_fetch = exp_fetch + 1;
    exp_stall = exp_stall + sreq + swait;
  endtask

  initial begin
    mem_req_ready  = 1'b0;
    mem_rsp_valid  = 1'b0;
    mem_rsp_data   = '0;
    mem_rsp_err    = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    exp_pc         = 32'h80000000;
    exp_fetch      = 0;
    exp_stall      = 0;
    repeat (3) step();
    check_reset_state();
    check_perf();
    rst = 1'b1;
    step();

    // Reset fetch with immediate handshakes, then a misaligned redirect.
    fetch(0, 0, 0, 32'h00000413, 1'b0, 1'b1, 32'h80000103);
    check("redirect_aligned", 64'(mem_req_addr), 64'h80000100);
    check_perf();

    // Long request stall, then consumer backpressure in HOLD.
    fetch(5, 0, 4, 32'h12345678, 1'b0, 1'b0, 32'h0);
    check_perf();

    // Wrap from the top of the address space, with an errored response.
    fetch(0, 1, 0, $urandom, 1'b0, 1'b1, 32'hFFFFFFFC);
    fetch(0, 0, 1, 32'hCAFEF00D, 1'b1, 1'b0, 32'h0);
    check("wrap_addr", 64'(mem_req_addr), 64'h0);

    for (int n = 0; n < 20; n++) begin
      fetch($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 2) == 0), $urandom);
    end
    check_perf();

    // Reset during WAIT; a stray response right after release must be dropped.
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    check("pre_rst_in_wait", 64'(mem_req_valid), 64'd0);
    rst = 1'b0;
    step();
    check_reset_state();
    rst           = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hDEADBEEF;
    step();
    mem_rsp_valid = 1'b0;
    check("post_rst_req_valid", 64'(mem_req_valid), 64'd1);
    check("post_rst_addr", 64'(mem_req_addr), 64'h80000000);
    check("post_rst_inst_valid", 64'(inst_valid), 64'd0);
    step();
    check("post_rst_inst_valid2", 64'(inst_valid), 64'd0);
    check("post_rst_inst", 64'(inst), 64'd0);
    exp_pc    = 32'h80000000;
    exp_fetch = 0;
    exp_stall = 1;
    check_perf();
    fetch(1, 0, 0, 32'h00100073, 1'b0, 1'b0, 32'h0);
    check("post_rst_next_addr", 64'(mem_req_addr), 64'h80000004);
    check_perf();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_24100012_ifu_req.md
YSYX_24100012_IFU_REQ -- requirements
Module: ysyx_24100012_ifu_req

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, 32, address width; DATA_WIDTH, 32, instruction width; ORIGIN_ADDR, 32'h80000000, PC after reset.
REQ-002 One clock, clk; reset rst is asynchronous and active-low.
REQ-003 Ports SHALL be:
- clk  in  1  clock
- rst  in  1  async active-low reset
- mem_req_valid  out  1  fetch request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  ADDR_WIDTH  fetch address
- mem_rsp_valid  in  1  response valid
- mem_rsp_data  in  DATA_WIDTH  fetched word
- mem_rsp_err  in  1  bus error on response
- inst_valid  out  1  instruction offered downstream
- inst_ready  in  1  downstream consumes instruction
- inst  out  DATA_WIDTH  instruction word
- inst_pc  out  ADDR_WIDTH  PC of inst
- inst_pc_next  out  ADDR_WIDTH  inst_pc+4
- inst_err  out  1  inst came from errored response
- redirect_valid  in  1  taken branch/jump, sampled on accept
- redirect_pc  in  ADDR_WIDTH  branch target

Function
REQ-004 FSM SHALL have states IDLE, REQ, WAIT, HOLD.
REQ-005 IDLE -> REQ unconditionally on the first clk edge after reset release.
REQ-006 In REQ, mem_req_valid=1 and mem_req_addr=pc; go to WAIT when mem_req_ready=1; addr stays stable until then.
REQ-007 In WAIT, on mem_rsp_valid=1 capture mem_rsp_data into inst and mem_rsp_err into inst_err, then go to HOLD; mem_rsp_valid outside WAIT SHALL be ignored.
REQ-008 In HOLD, inst_valid=1; inst, inst_pc, inst_pc_next, inst_err stay stable until inst_valid&&inst_ready.
REQ-009 On accept, pc <= redirect_valid ? {redirect_pc[31:2],2'b00} : pc+4, and state -> REQ; redirect_valid SHALL have no effect in any other cycle.
REQ-010 Best-case throughput: one instruction per 3 cycles (REQ, WAIT, HOLD), with ready and rsp_valid each asserted on the first cycle they are sampled.
REQ-011 pc+4 SHALL wrap modulo 2^ADDR_WIDTH (32'hFFFFFFFC -> 32'h0).
REQ-012 inst_valid SHALL be 0 in IDLE, REQ, WAIT; mem_req_valid SHALL be 0 outside REQ.
REQ-013 inst_pc_next SHALL be combinational inst_pc+4.

Reset
REQ-014 While rst=0: state=IDLE, pc=ORIGIN_ADDR, inst=0, inst_err=0, mem_req_valid=0, inst_valid=0, perf counters=0.
REQ-015 Reset asserted mid-transaction SHALL abandon it; a late response after release SHALL be dropped per REQ-007.

Configuration
REQ-016 Macro YSYX_24100012_IFU_PERF_EN defined: add outputs perf_fetch_cnt (32, +1 per accept) and perf_stall_cnt (32, +1 per cycle in REQ with mem_req_ready=0 or in WAIT with mem_rsp_valid=0), both wrapping.
REQ-017 Macro undefined: those ports and counters SHALL not exist; all other behaviour is identical.

Structure
REQ-018 State encoding enum and the IFU_NOP constant 32'h00000013 SHALL live in shared package ysyx_24100012_pkg; ORIGIN_ADDR default SHALL come from the same package.
REQ-019 PC register SHALL use the existing ysyx_24100012_Reg; no other sub-module.

Verification
REQ-020 Reset release, ready=1, rsp one cycle after request with data 32'h00000413 -> mem_req_addr=32'h80000000, inst_valid on 3rd cycle, inst_pc=32'h80000000, inst_pc_next=32'h80000004.
REQ-021 Accept with redirect_valid=1, redirect_pc=32'h80000103 -> next mem_req_addr=32'h80000100.
REQ-022 mem_req_ready held 0 for 5 cycles -> mem_req_addr constant, inst_valid=0 throughout, perf_stall_cnt=5 (macro on).
REQ-023 inst_ready=0 for 4 cycles in HOLD -> inst/inst_pc stable, no new mem_req_valid; 20 accepts -> perf_fetch_cnt=20.
REQ-024 pc=32'hFFFFFFFC accepted without redirect -> next mem_req_addr=32'h0; rsp with mem_rsp_err=1 -> inst_err=1 with that inst.
REQ-025 rst=0 asserted in WAIT, rsp_valid pulsed one cycle after release -> pulse ignored, mem_req_addr=32'h80000000, inst_valid=0.
